vga_raster_monitor: RTL

- Sink-side checker for the VGA raster stream that the display subsystem drives out (vga_clk, hs, vs, blank, 8-bit R/G/B).
- Samples the raster in the 50 MHz system clock domain and rebuilds pixel, line and frame timing.
- Checks the rebuilt timing against the 640x480@60 parameters, reports lock and sticky errors, and produces a per-frame pixel checksum.
- Used on-chip and in simulation to prove the raster output is frame-correct.

---
 rtl/vga_raster_monitor.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_raster_monitor.sv
// Sink-side VGA raster checker: rebuilds pixel/line/frame timing from a sampled
// raster, tracks lock, latches sticky timing errors and sums active RGB per frame.
module vga_raster_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned HSYNC_W     = 96,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        err_clear,
  output logic        locked,
  output logic [3:0]  err_flags,
  output logic        frame_valid,
  output logic [23:0] frame_sum,
  output logic [15:0] frame_count,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y
);

  localparam logic [9:0]  H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0]  H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  HSYNC_W_C  = 10'(HSYNC_W);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
  localparam logic [11:0] IDLE_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic [27:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic        clk_prev_q, clk_prev_d, ps_q, ps_d;
  logic [26:0] smp_q, smp_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  h_cnt_q, h_cnt_d, hact_cnt_q, hact_cnt_d, hsw_cnt_q, hsw_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d, vact_cnt_q, vact_cnt_d;
  logic [23:0] acc_q, acc_d;
  logic [11:0] idle_q, idle_d;
  logic [3:0]  good_q, good_d;
  logic        frame_err_q, frame_err_d;
  state_e      state_q, state_d;
  logic        locked_q, locked_d, frame_valid_q, frame_valid_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [23:0] frame_sum_q, frame_sum_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;

  logic        s_hs, s_vs, s_blank, hs_fall, vs_fall, tracking, frame_bad;
  logic [9:0]  rgb_sum, line_inc, vact_inc;
  logic [23:0] acc_inc;
  logic [3:0]  err_set;

  assign s_hs     = smp_q[26];
  assign s_vs     = smp_q[25];
  assign s_blank  = smp_q[24];
  assign rgb_sum  = {2'b00, smp_q[23:16]} + {2'b00, smp_q[15:8]} + {2'b00, smp_q[7:0]};
  assign hs_fall  = ps_q & hs_prev_q & ~s_hs;
  assign vs_fall  = ps_q & vs_prev_q & ~s_vs;
  assign tracking = (state_q != ST_SEARCH);

  // Data is pipelined alongside vga_clk so the sample lines up with the strobe.
  always_comb begin
    sync1_d    = {vga_clk, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b};
    sync2_d    = sync1_q;
    clk_prev_d = sync2_q[27];
    ps_d       = sync2_q[27] & ~clk_prev_q;
    smp_d      = sync2_q[26:0];
  end

  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    hact_cnt_d    = hact_cnt_q;
    hsw_cnt_d     = hsw_cnt_q;
    line_cnt_d    = line_cnt_q;
    vact_cnt_d    = vact_cnt_q;
    acc_d         = acc_q;
    idle_d        = idle_q;
    good_d        = good_q;
    frame_err_d   = frame_err_q;
    state_d       = state_q;
    frame_sum_d   = frame_sum_q;
    frame_count_d = frame_count_q;
    frame_valid_d = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    err_set       = 4'b0000;

    // Line boundary is resolved before the frame boundary on a shared strobe.
    if (hs_fall && tracking) begin
      err_set[0] = (h_cnt_q != H_TOTAL_C);
      err_set[1] = (hact_cnt_q != 10'd0) &&
                   ((hact_cnt_q != H_ACTIVE_C) || (hsw_cnt_q != HSYNC_W_C));
      line_inc   = sat_inc10(line_cnt_q);
      vact_inc   = (hact_cnt_q != 10'd0) ? sat_inc10(vact_cnt_q) : vact_cnt_q;
    end else begin
      line_inc   = line_cnt_q;
      vact_inc   = vact_cnt_q;
    end
    if (vs_fall && tracking) begin
      err_set[2] = (line_inc != V_TOTAL_C);
      err_set[3] = (vact_inc != V_ACTIVE_C);
    end else begin
      err_set[3:2] = 2'b00;
    end
    frame_bad = frame_err_q | (|err_set);
    acc_inc   = (ps_q && s_blank) ? acc_q + {14'd0, rgb_sum} : acc_q;

    if (ps_q) begin
      idle_d      = 12'd0;
      hs_prev_d   = s_hs;
      vs_prev_d   = s_vs;
      acc_d       = acc_inc;
      line_cnt_d  = line_inc;
      vact_cnt_d  = vact_inc;
      frame_err_d = frame_bad;
      if (hs_fall) begin
        h_cnt_d    = 10'd1;
        hact_cnt_d = {9'd0, s_blank};
        hsw_cnt_d  = {9'd0, ~s_hs};
        pix_x_d    = 10'd0;
        pix_y_d    = vact_inc[8:0];
      end else begin
        h_cnt_d    = sat_inc10(h_cnt_q);
        hact_cnt_d = s_blank ? sat_inc10(hact_cnt_q) : hact_cnt_q;
        hsw_cnt_d  = s_hs ? hsw_cnt_q : sat_inc10(hsw_cnt_q);
        pix_x_d    = s_blank ? hact_cnt_q : pix_x_q;
      end
      if (vs_fall) begin
        acc_d       = 24'd0;
        line_cnt_d  = 10'd0;
        vact_cnt_d  = 10'd0;
        pix_y_d     = 9'd0;
        frame_err_d = 1'b0;
        case (state_q)
          ST_SEARCH: begin
            state_d = ST_MEASURE;
            good_d  = 4'd0;
          end
          ST_MEASURE: begin
            if (frame_bad) begin
              good_d = 4'd0;
            end else if (good_q + 4'd1 >= LOCK_C) begin
              good_d  = good_q + 4'd1;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + 4'd1;
            end
          end
          ST_LOCKED: begin
            frame_sum_d   = acc_inc;
            frame_count_d = frame_count_q + 16'd1;
            frame_valid_d = 1'b1;
            if (frame_bad) begin
              state_d = ST_MEASURE;
              good_d  = 4'd0;
            end else begin
              state_d = ST_LOCKED;
            end
          end
          default: begin
            state_d = ST_SEARCH;
            good_d  = 4'd0;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end else if (idle_q == IDLE_MAX) begin
      // Raster gone: fall back to searching, sticky errors are kept.
      state_d     = ST_SEARCH;
      good_d      = 4'd0;
      frame_err_d = 1'b0;
    end else begin
      idle_d = idle_q + 12'd1;
    end

    err_flags_d = (err_clear ? 4'b0000 : err_flags_q) | err_set;
    locked_d    = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;  sync2_q <= '0;  clk_prev_q <= 1'b0;  ps_q <= 1'b0;  smp_q <= '0;
      hs_prev_q <= 1'b0;  vs_prev_q <= 1'b0;
      h_cnt_q <= '0;  hact_cnt_q <= '0;  hsw_cnt_q <= '0;  line_cnt_q <= '0;  vact_cnt_q <= '0;
      acc_q <= '0;  idle_q <= '0;  good_q <= '0;  frame_err_q <= 1'b0;  state_q <= ST_SEARCH;
      locked_q <= 1'b0;  err_flags_q <= '0;  frame_valid_q <= 1'b0;  frame_sum_q <= '0;
      frame_count_q <= '0;  pix_x_q <= '0;  pix_y_q <= '0;
    end else begin
      sync1_q <= sync1_d;  sync2_q <= sync2_d;  clk_prev_q <= clk_prev_d;  ps_q <= ps_d;  smp_q <= smp_d;
      hs_prev_q <= hs_prev_d;  vs_prev_q <= vs_prev_d;
      h_cnt_q <= h_cnt_d;  hact_cnt_q <= hact_cnt_d;  hsw_cnt_q <= hsw_cnt_d;
      line_cnt_q <= line_cnt_d;  vact_cnt_q <= vact_cnt_d;
      acc_q <= acc_d;  idle_q <= idle_d;  good_q <= good_d;  frame_err_q <= frame_err_d;  state_q <= state_d;
      locked_q <= locked_d;  err_flags_q <= err_flags_d;  frame_valid_q <= frame_valid_d;
      frame_sum_q <= frame_sum_d;  frame_count_q <= frame_count_d;  pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;
    end
  end

  assign locked      = locked_q;
  assign err_flags   = err_flags_q;
  assign frame_valid = frame_valid_q;
  assign frame_sum   = frame_sum_q;
  assign frame_count = frame_count_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule
